// File: rtl/msec_alarm_pkg.sv
// Shared constants for the millisecond alarm controller: register map, CTRL/STATUS
// bit positions, FSM state encodings and the wrap-safe deadline test.
package msec_alarm_pkg;

    localparam int ADDR_ELAPSED = 0;
    localparam int ADDR_COMPARE = 1;
    localparam int ADDR_PERIOD  = 2;
    localparam int ADDR_CTRL    = 3;
    localparam int ADDR_STATUS  = 4;
    localparam int ADDR_WDOG    = 5;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_PERIOD = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_PENDING = 0;
    localparam int STAT_ARMED   = 1;

    localparam logic [1:0] DISARMED = 2'd0;
    localparam logic [1:0] ARMED    = 2'd1;
    localparam logic [1:0] FIRED    = 2'd2;

    // Signed difference keeps the test correct across the 2^32 ms wrap.
    function automatic logic deadline_hit(input logic [31:0] elapsed, input logic [31:0] cmp);
        logic [31:0] diff;
        diff = elapsed - cmp;
        return ~diff[31];
    endfunction

endpackage

// File: rtl/msec_alarm_if.sv
// Single-cycle request / one-cycle acknowledge register bus of the alarm controller.
interface msec_alarm_if #(
    parameter int ADDR_W = 3
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/msec_alarm_regs.sv
// Bus decode, registered ack/rdata, PERIOD/CTRL storage and STATUS W1C strobe.
// MSEC_ALARM_WDOG_EN adds the WDOG_LIMIT register at word address 5.
module msec_alarm_regs
    import msec_alarm_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_ack,
    input  logic [31:0]       msec_elapsed,
    input  logic [31:0]       compare_val,
    input  logic              pending,
    input  logic              armed,
    output logic [31:0]       period_val,
    output logic [2:0]        ctrl_val,
    output logic              wr_compare,
    output logic              wr_ctrl,
    output logic              pend_clr
`ifdef MSEC_ALARM_WDOG_EN
    ,
    output logic [31:0]       wdog_limit
`endif
);

    logic [31:0] period_q, period_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_mux_s;
    logic        wr_s;
`ifdef MSEC_ALARM_WDOG_EN
    logic [31:0] wdog_q, wdog_d;
`endif

    // Address decode: read mux, write strobes and next register values.
    always_comb begin
        wr_s       = bus_req & bus_we;
        wr_compare = 1'b0;
        wr_ctrl    = 1'b0;
        pend_clr   = 1'b0;
        rd_mux_s   = 32'd0;
        period_d   = period_q;
        ctrl_d     = ctrl_q;
`ifdef MSEC_ALARM_WDOG_EN
        wdog_d     = wdog_q;
`endif
        case (bus_addr)
            ADDR_W'(ADDR_ELAPSED): rd_mux_s = msec_elapsed;
            ADDR_W'(ADDR_COMPARE): begin
                rd_mux_s   = compare_val;
                wr_compare = wr_s;
            end
            ADDR_W'(ADDR_PERIOD): begin
                rd_mux_s = period_q;
                if (wr_s) period_d = bus_wdata;
                else      period_d = period_q;
            end
            ADDR_W'(ADDR_CTRL): begin
                rd_mux_s = {29'd0, ctrl_q};
                wr_ctrl  = wr_s;
                if (wr_s) ctrl_d = bus_wdata[2:0];
                else      ctrl_d = ctrl_q;
            end
            ADDR_W'(ADDR_STATUS): begin
                rd_mux_s = {30'd0, armed, pending};
                pend_clr = wr_s & bus_wdata[STAT_PENDING];
            end
`ifdef MSEC_ALARM_WDOG_EN
            ADDR_W'(ADDR_WDOG): begin
                rd_mux_s = wdog_q;
                if (wr_s) wdog_d = bus_wdata;
                else      wdog_d = wdog_q;
            end
`endif
            default: rd_mux_s = 32'd0;
        endcase

        ack_d = bus_req;
        // rdata holds its last value between acks; writes return zero.
        if (bus_req) rdata_d = bus_we ? 32'd0 : rd_mux_s;
        else         rdata_d = rdata_q;
    end

    // Register state and bus response pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q <= 32'd0;
            ctrl_q   <= 3'd0;
            ack_q    <= 1'b0;
            rdata_q  <= 32'd0;
`ifdef MSEC_ALARM_WDOG_EN
            wdog_q   <= 32'd0;
`endif
        end else begin
            period_q <= period_d;
            ctrl_q   <= ctrl_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
`ifdef MSEC_ALARM_WDOG_EN
            wdog_q   <= wdog_d;
`endif
        end
    end

    assign bus_ack    = ack_q;
    assign bus_rdata  = rdata_q;
    assign period_val = period_q;
    assign ctrl_val   = ctrl_q;
`ifdef MSEC_ALARM_WDOG_EN
    assign wdog_limit = wdog_q;
`endif

endmodule

// File: rtl/msec_alarm_ctrl.sv
// Millisecond alarm controller: one-shot/periodic deadline FSM with level irq.
// Defining MSEC_ALARM_WDOG_EN adds the WDOG_LIMIT register and the wdog_rst pulse output.
module msec_alarm_ctrl
    import msec_alarm_pkg::*;
#(
    parameter int          ADDR_W        = 3,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] msec_elapsed,
    msec_alarm_if.slave bus,
    output logic        irq
`ifdef MSEC_ALARM_WDOG_EN
    ,
    output logic        wdog_rst
`endif
);

    logic [1:0]  state_q, state_d;
    logic [31:0] compare_q, compare_d;
    logic        pending_q, pending_d;
    logic [31:0] period_s;
    logic [2:0]  ctrl_s;
    logic        wr_compare_s, wr_ctrl_s, pend_clr_s;
    logic        hit_s, pend_set_s, disarm_s;
`ifdef MSEC_ALARM_WDOG_EN
    logic [31:0] wdog_limit_s;
    logic [31:0] wdog_cap_q, wdog_cap_d;
    logic        wdog_done_q, wdog_done_d;
    logic        wdog_rst_q, wdog_rst_d;
`endif

    msec_alarm_regs #(.ADDR_W(ADDR_W)) u_regs (
        .clk          (clk),
        .reset        (reset),
        .bus_req      (bus.bus_req),
        .bus_we       (bus.bus_we),
        .bus_addr     (bus.bus_addr),
        .bus_wdata    (bus.bus_wdata),
        .bus_rdata    (bus.bus_rdata),
        .bus_ack      (bus.bus_ack),
        .msec_elapsed (msec_elapsed),
        .compare_val  (compare_q),
        .pending      (pending_q),
        .armed        (state_q == ARMED),
        .period_val   (period_s),
        .ctrl_val     (ctrl_s),
        .wr_compare   (wr_compare_s),
        .wr_ctrl      (wr_ctrl_s),
        .pend_clr     (pend_clr_s)
`ifdef MSEC_ALARM_WDOG_EN
        ,
        .wdog_limit   (wdog_limit_s)
`endif
    );

    assign hit_s = deadline_hit(msec_elapsed, compare_q);

    // Alarm FSM; a COMPARE write masks a simultaneous hit, and a set beats a W1C.
    always_comb begin
        state_d    = state_q;
        compare_d  = compare_q;
        pend_set_s = 1'b0;
        disarm_s   = wr_ctrl_s & ~bus.bus_wdata[CTRL_EN];
        if (wr_compare_s) compare_d = bus.bus_wdata;
        else              compare_d = compare_q;

        case (state_q)
            DISARMED: begin
                if (wr_ctrl_s && bus.bus_wdata[CTRL_EN]) state_d = ARMED;
                else                                     state_d = DISARMED;
            end
            ARMED: begin
                if (hit_s && !wr_compare_s && !disarm_s) begin
                    pend_set_s = 1'b1;
                    if (ctrl_s[CTRL_PERIOD] && (period_s != 32'd0)) begin
                        compare_d = compare_q + period_s;
                    end else begin
                        state_d = FIRED;
                    end
                end else begin
                    state_d = ARMED;
                end
            end
            FIRED: begin
                if (wr_compare_s && ctrl_s[CTRL_EN]) state_d = ARMED;
                else                                 state_d = FIRED;
            end
            default: state_d = DISARMED;
        endcase

        if (disarm_s) state_d = DISARMED;
        else          state_d = state_d;

        pending_d = pend_set_s | (pending_q & ~pend_clr_s);
    end

    // FSM, deadline and pending flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= DISARMED;
            compare_q <= RESET_COMPARE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            compare_q <= compare_d;
            pending_q <= pending_d;
        end
    end

    assign irq = pending_q & ctrl_s[CTRL_IRQ_EN];

`ifdef MSEC_ALARM_WDOG_EN
    // Watchdog: one pulse per pending episode once the limit has elapsed since it rose.
    always_comb begin
        if (pending_d && !pending_q) wdog_cap_d = msec_elapsed;
        else                         wdog_cap_d = wdog_cap_q;
        wdog_rst_d = pending_q && (wdog_limit_s != 32'd0) && !wdog_done_q &&
                     ((msec_elapsed - wdog_cap_q) >= wdog_limit_s);
        if (pending_q) wdog_done_d = wdog_done_q | wdog_rst_d;
        else           wdog_done_d = 1'b0;
    end

    // Watchdog capture, one-shot latch and registered pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cap_q  <= 32'd0;
            wdog_done_q <= 1'b0;
            wdog_rst_q  <= 1'b0;
        end else begin
            wdog_cap_q  <= wdog_cap_d;
            wdog_done_q <= wdog_done_d;
            wdog_rst_q  <= wdog_rst_d;
        end
    end

    assign wdog_rst = wdog_rst_q;
`endif

endmodule
